// File: rtl/rs_codec_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rs_codec_pkg                                                              |
// | Shared constants and types for the RS codec back-end blocks.              |
// | Contents: default symbol width / codeword geometry, index width and the   |
// |           write-side state encoding of the message extractor.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package rs_codec_pkg;

    localparam int WORD_LENGTH = 8;
    localparam int RS_N        = 15;
    localparam int RS_K        = 11;

    // Wide enough to count every beat of a codeword (0..n)
    localparam int IDX_W = $clog2(RS_N + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/rs_msg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rs_msg_bank                                                               |
// | Two-bank simple dual-port register array with per-bank full flags.        |
// | Ports: clk/rst        clock, synchronous active-high reset                |
// |        we_i..wdata_i  write port (bank, address, data)                    |
// |        rbank_i/raddr_i read address, rdata_o registered read data         |
// |        set_i/set_bank_i  mark a bank full                                 |
// |        clr_i/clr_bank_i  mark a bank empty                                |
// |        full_o         registered full flag per bank                       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module rs_msg_bank
    import rs_codec_pkg::*;
#(
    parameter int SYM_W = WORD_LENGTH,
    parameter int DEPTH = RS_K,
    parameter int AW    = IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic             wbank_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [SYM_W-1:0] wdata_i,
    input  logic             rbank_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [SYM_W-1:0] rdata_o,
    input  logic             set_i,
    input  logic             set_bank_i,
    input  logic             clr_i,
    input  logic             clr_bank_i,
    output logic [1:0]       full_o
);

    logic [SYM_W-1:0] mem_q [2][DEPTH];
    logic [SYM_W-1:0] rdata_q;
    logic [1:0]       full_q;

    // Storage carries no reset; contents only matter once a bank is full
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wbank_i][waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[rbank_i][raddr_i];
        end
    end

    // Set and clear always target different banks: only a non-full bank
    // is ever committed and only a full bank is ever released.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
        end else begin
            if (set_i) begin
                full_q[set_bank_i] <= 1'b1;
            end
            if (clr_i) begin
                full_q[clr_bank_i] <= 1'b0;
            end
        end
    end

    assign rdata_o = rdata_q;
    assign full_o  = full_q;

endmodule
`default_nettype wire

// File: rtl/rs_msg_extractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rs_msg_extractor                                                          |
// | Strips parity from the RS decoder output, buffers the message symbols of  |
// | each good codeword in one of two banks and replays them on a valid/ready  |
// | message stream. Bad, malformed or unbufferable codewords are dropped.     |
// | Ports: clk/rst              clock, synchronous active-high reset          |
// |        d_valid_i..d_symbol_i decoder stream (no backpressure)             |
// |        m_valid_o/m_ready_i  message handshake                             |
// |        m_symbol_o/m_start_o/m_end_o message data and framing              |
// |        drop_pulse_o         one-cycle pulse per discarded codeword        |
// |        cnt_ok_o/cnt_drop_o  saturating committed/dropped counters         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module rs_msg_extractor #(
    parameter int WORD_LENGTH = rs_codec_pkg::WORD_LENGTH,
    parameter int N           = rs_codec_pkg::RS_N,
    parameter int K           = rs_codec_pkg::RS_K,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   d_valid_i,
    input  logic                   d_start_i,
    input  logic                   d_end_i,
    input  logic                   d_error_i,
    input  logic [WORD_LENGTH-1:0] d_symbol_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [WORD_LENGTH-1:0] m_symbol_o,
    output logic                   m_start_o,
    output logic                   m_end_o,
    output logic                   drop_pulse_o,
    output logic [CNT_W-1:0]       cnt_ok_o,
    output logic [CNT_W-1:0]       cnt_drop_o
);

    import rs_codec_pkg::*;

    localparam int            IW       = $clog2(N + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] MSG_IDX  = IW'(K);
    localparam logic [IW-1:0] RD_LAST  = IW'(K - 1);

    wr_state_t        state_q, state_d;
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic             wr_bank_q, wr_bank_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] cnt_ok_q, cnt_drop_q;
    logic             drop_q;

    logic             w_we;
    logic [IW-1:0]    w_waddr;
    logic             w_commit;
    logic             w_drop;
    logic             w_release;
    logic             w_hs;
    logic [1:0]       w_full;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        w_we      = 1'b0;
        w_waddr   = wr_idx_q;
        w_commit  = 1'b0;
        w_drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_valid_i && d_start_i) begin
                    if (d_end_i) begin
                        w_drop = 1'b1;
                    end else if (!w_full[0] || !w_full[1]) begin
                        // Bank 1 is used only when bank 0 is occupied
                        wr_bank_d = w_full[0];
                        w_we      = 1'b1;
                        w_waddr   = '0;
                        wr_idx_d  = IW'(1);
                        state_d   = RECV;
                    end else begin
                        w_drop  = 1'b1;
                        state_d = DISCARD;
                    end
                end
            end
            RECV: begin
                if (d_valid_i) begin
                    if (d_start_i) begin
                        // A new codeword aborts the current one and reuses its bank
                        w_drop = 1'b1;
                        if (d_end_i) begin
                            state_d = IDLE;
                        end else begin
                            w_we     = 1'b1;
                            w_waddr  = '0;
                            wr_idx_d = IW'(1);
                        end
                    end else if (d_end_i) begin
                        if (wr_idx_q == LAST_IDX && !d_error_i) begin
                            w_commit = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
                        state_d = IDLE;
                    end else if (wr_idx_q == LAST_IDX) begin
                        // n beats seen without an end marker
                        w_drop  = 1'b1;
                        state_d = DISCARD;
                    end else begin
                        w_we     = (wr_idx_q < MSG_IDX);
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (d_valid_i && d_end_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    assign m_valid_o = w_full[rd_bank_q];
    assign w_hs      = m_valid_o && m_ready_i;

    always_comb begin
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        w_release = 1'b0;
        if (w_hs) begin
            if (rd_idx_q == RD_LAST) begin
                w_release = 1'b1;
                rd_idx_d  = '0;
                rd_bank_d = ~rd_bank_q;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end else if (!w_full[rd_bank_q] && w_commit) begin
            // Reader is idle, so the bank being committed is the oldest;
            // follow it even if lowest-free selection put it on the other bank.
            rd_bank_d = wr_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_q  <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            rd_idx_q  <= rd_idx_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    assign m_start_o = m_valid_o && (rd_idx_q == '0);
    assign m_end_o   = m_valid_o && (rd_idx_q == RD_LAST);

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ok_q   <= '0;
            cnt_drop_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= w_drop;
            if (w_commit && cnt_ok_q != '1) begin
                cnt_ok_q <= cnt_ok_q + 1'b1;
            end
            if (w_drop && cnt_drop_q != '1) begin
                cnt_drop_q <= cnt_drop_q + 1'b1;
            end
        end
    end

    assign drop_pulse_o = drop_q;
    assign cnt_ok_o     = cnt_ok_q;
    assign cnt_drop_o   = cnt_drop_q;

    // ------------------------------------------------------------------
    // Storage; read address is next-state so m_symbol tracks rd_idx
    // ------------------------------------------------------------------
    rs_msg_bank #(
        .SYM_W (WORD_LENGTH),
        .DEPTH (K),
        .AW    (IW)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .we_i       (w_we),
        .wbank_i    (wr_bank_d),
        .waddr_i    (w_waddr),
        .wdata_i    (d_symbol_i),
        .rbank_i    (rd_bank_d),
        .raddr_i    (rd_idx_d),
        .rdata_o    (m_symbol_o),
        .set_i      (w_commit),
        .set_bank_i (wr_bank_q),
        .clr_i      (w_release),
        .clr_bank_i (rd_bank_q),
        .full_o     (w_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_rs_msg_extractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rs_msg_extractor                                                       |
// | Self-checking bench: frame-level queue model plus directed scenarios.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_rs_msg_extractor;

    localparam int WL   = 8;
    localparam int N    = 15;
    localparam int K    = 11;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_valid, d_start, d_end, d_error;
    logic [WL-1:0] d_symbol;
    logic          m_valid, m_ready, m_start, m_end;
    logic [WL-1:0] m_symbol;
    logic          drop_pulse;
    logic [CW-1:0] cnt_ok, cnt_drop;

    int total = 0;
    int bad   = 0;

    rs_msg_extractor #(
        .WORD_LENGTH (WL),
        .N           (N),
        .K           (K),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .d_valid_i    (d_valid),
        .d_start_i    (d_start),
        .d_end_i      (d_end),
        .d_error_i    (d_error),
        .d_symbol_i   (d_symbol),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_symbol_o   (m_symbol),
        .m_start_o    (m_start),
        .m_end_o      (m_end),
        .drop_pulse_o (drop_pulse),
        .cnt_ok_o     (cnt_ok),
        .cnt_drop_o   (cnt_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: committed messages as a flat symbol queue (K per message),
    // the codeword being collected as a queue, and a skip flag.
    // ------------------------------------------------------------------
    logic [WL-1:0] st_q[$];
    logic [WL-1:0] cur[$];
    int  pos = 0;
    bit  coll = 0, skip = 0, drop_e = 0, after_rst = 0;
    int  ok_m = 0, dr_m = 0;

    always @(posedge clk) begin : model
        int nstored;
        bit drop;
        drop = 0;
        if (rst) begin
            st_q.delete(); cur.delete();
            pos = 0; coll = 0; skip = 0; ok_m = 0; dr_m = 0;
            after_rst = 1;
        end else begin
            after_rst = 0;
            nstored = st_q.size() / K;
            if (nstored > 0 && m_ready) begin
                pos++;
                if (pos == K) begin
                    repeat (K) void'(st_q.pop_front());
                    pos = 0;
                end
            end
            if (d_valid) begin
                if (coll) begin
                    if (d_start) begin
                        drop = 1; cur.delete();
                        if (d_end) coll = 0; else cur.push_back(d_symbol);
                    end else if (d_end) begin
                        if (cur.size() + 1 == N && !d_error) begin
                            for (int i = 0; i < K; i++) st_q.push_back(cur[i]);
                            if (ok_m < MAXC) ok_m++;
                        end else drop = 1;
                        coll = 0; cur.delete();
                    end else if (cur.size() + 1 == N) begin
                        drop = 1; coll = 0; skip = 1; cur.delete();
                    end else cur.push_back(d_symbol);
                end else if (skip) begin
                    if (d_end) skip = 0;
                end else if (d_start) begin
                    if (d_end) drop = 1;
                    else if (nstored < 2) begin
                        coll = 1; cur.delete(); cur.push_back(d_symbol);
                    end else begin
                        drop = 1; skip = 1;
                    end
                end
            end
            if (drop && dr_m < MAXC) dr_m++;
        end
        drop_e = drop;
    end

    // ------------------------------------------------------------------
    // Compare process and output log
    // ------------------------------------------------------------------
    logic [WL-1:0] got[$];
    int pulses = 0;

    always @(negedge clk) begin
        check("m_valid", m_valid, st_q.size() > 0);
        if (st_q.size() > 0) begin
            check("m_symbol", m_symbol, st_q[pos]);
            check("m_start", m_start, pos == 0);
            check("m_end", m_end, pos == K - 1);
        end else begin
            check("m_start_idle", m_start, 0);
            check("m_end_idle", m_end, 0);
        end
        if (after_rst) check("m_symbol_rst", m_symbol, 0);
        check("drop_pulse", drop_pulse, drop_e);
        check("cnt_ok", cnt_ok, ok_m);
        check("cnt_drop", cnt_drop, dr_m);
        if (m_valid && m_ready) got.push_back(m_symbol);
        if (drop_pulse) pulses++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic cyc(input bit v, input bit s, input bit e, input bit er, input logic [WL-1:0] sym);
        d_valid = v; d_start = s; d_end = e; d_error = er; d_symbol = sym;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, '0);
    endtask

    task automatic frame(input int len, input int base, input bit err, input bit with_end);
        for (int i = 0; i < len; i++)
            cyc(1'b1, i == 0, with_end && (i == len - 1), err && (i == len - 1), WL'(base + i));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        got.delete();
        pulses = 0;
    endtask

    task automatic check_seq(input string name, input int idx0, input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (idx0 + i < got.size()) check(name, got[idx0 + i], base + i);
            else check(name, 32'hFFFF_FFFF, base + i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0", 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; m_ready = 1'b1;
        d_valid = 0; d_start = 0; d_end = 0; d_error = 0; d_symbol = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_cnt_ok", cnt_ok, 0);
        check("rst_cnt_drop", cnt_drop, 0);
        check("rst_drop_pulse", drop_pulse, 0);
        do_reset();

        // Good codeword, free-running consumer
        frame(15, 1, 0, 1);
        idle(15);
        check("t1_len", got.size(), 11);
        check_seq("t1_data", 0, 1, 11);
        check("t1_ok", cnt_ok, 1);
        check("t1_pulses", pulses, 0);

        // Uncorrectable codeword
        do_reset();
        frame(15, 1, 1, 1);
        idle(15);
        check("t2_len", got.size(), 0);
        check("t2_pulses", pulses, 1);
        check("t2_drop", cnt_drop, 1);

        // Both banks full, third codeword dropped
        do_reset();
        m_ready = 1'b0;
        frame(15, 1, 0, 1);
        frame(15, 21, 0, 1);
        frame(15, 41, 0, 1);
        idle(3);
        check("t3_pulses", pulses, 1);
        m_ready = 1'b1;
        idle(30);
        check("t3_len", got.size(), 22);
        check_seq("t3_cw1", 0, 1, 11);
        check_seq("t3_cw2", 11, 21, 11);
        check("t3_ok", cnt_ok, 2);
        check("t3_drop", cnt_drop, 1);

        // Length-1, short and long frames, then a good one
        do_reset();
        cyc(1, 1, 1, 0, 8'd9);
        frame(10, 1, 0, 1);
        frame(20, 1, 0, 1);
        frame(15, 70, 0, 1);
        idle(15);
        check("t4_pulses", pulses, 3);
        check("t4_drop", cnt_drop, 3);
        check("t4_len", got.size(), 11);
        check_seq("t4_data", 0, 70, 11);

        // Restart inside a codeword
        do_reset();
        frame(5, 100, 0, 0);
        frame(15, 200, 0, 1);
        idle(15);
        check("t5_drop", cnt_drop, 1);
        check("t5_len", got.size(), 11);
        check_seq("t5_data", 0, 200, 11);

        // Reset in the middle of a codeword
        do_reset();
        frame(7, 90, 0, 0);
        do_reset();
        frame(15, 50, 0, 1);
        idle(15);
        check("t6_ok", cnt_ok, 1);
        check("t6_drop", cnt_drop, 0);
        check("t6_len", got.size(), 11);
        check_seq("t6_data", 0, 50, 11);

        // Drop counter saturation
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1, 1, 1, 0, WL'(i));
        idle(2);
        check("t7_drop_sat", cnt_drop, MAXC);
        check("t7_pulses", pulses, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
